controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller.sv | 192 +++++++++++++++++++
 tb/tb_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
// Instruction-sequencing FSM for a small register-file datapath. It fetches an
// instruction, optionally settles for FETCH_WAIT cycles, captures it into IR,
// then drives one-hot bus selects and load enables for each execute cycle.
//
// Parameters
//   FETCH_WAIT   settle cycles (0-3) between the increment pulse and IR capture
//
// Optional feature macro
//   CONTROLLER_HALT_EN   when defined, instruction 0x00 enters HALT instead of
//                        executing as mv R0,R0; HALT exits only on reset
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   run          in   level; high permits fetching the next instruction
//   instruction  in   [7:6] opcode, [5:3] rx, [2:0] ry/immediate
//   rout         out  one-hot bus driver select (0-7 R0-R7, 8 G, 9 A, 10 EXTERN)
//   ren          out  register load enables (0-7 R0-R7, 8 G, 9 A)
//   addxor       out  ALU select, 0 add / 1 xor
//   increment    out  program-counter advance pulse (used as a clock downstream)
//   busy         out  high in any state other than IDLE/HALT
//   done         out  pulse in the final execute cycle of each instruction
//   halted       out  high in HALT
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for run
// FETCH | increment pulse to the program counter
// WAIT  | settle cycles before IR capture
// EX1   | mv/mvi transfer, or add/xor operand rx -> A
// EX2   | add/xor operand ry through ALU -> G
// EX3   | add/xor result G -> rx
// HALT  | stopped until reset
module controller #(
  parameter int FETCH_WAIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  instruction,
  output logic [15:0] rout,
  output logic [15:0] ren,
  output logic        addxor,
  output logic        increment,
  output logic        busy,
  output logic        done,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EX1, S_EX2, S_EX3, S_HALT
  } state_t;

  localparam logic [1:0] WAIT_LOAD = (FETCH_WAIT > 0) ? 2'(FETCH_WAIT - 1) : 2'd0;

  state_t      state, state_n;
  logic [7:0]  ir, ir_d;
  logic [1:0]  wcnt, wcnt_n;
  logic        load_ir;

  logic [15:0] rout_d, ren_d;
  logic        addxor_d, increment_d, busy_d, done_d;
`ifdef CONTROLLER_HALT_EN
  logic        halted_d, halted_q;
`endif

  // State register; outputs are registered copies of the next-state decode so
  // they change only on the clock edge and never glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ir        <= 8'h00;
      wcnt      <= 2'd0;
      rout      <= 16'h0000;
      ren       <= 16'h0000;
      addxor    <= 1'b0;
      increment <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      ir        <= ir_d;
      wcnt      <= wcnt_n;
      rout      <= rout_d;
      ren       <= ren_d;
      addxor    <= addxor_d;
      increment <= increment_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

`ifdef CONTROLLER_HALT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // Next-state logic. The wait timer is a down-counter loaded on FETCH exit;
  // terminal count zero ends the settle period and captures IR.
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    load_ir = 1'b0;
    case (state)
      S_IDLE:  if (run) state_n = S_FETCH;
      S_FETCH: begin
        if (FETCH_WAIT > 0) begin
          state_n = S_WAIT;
          wcnt_n  = WAIT_LOAD;
        end else begin
          load_ir = 1'b1;
          state_n = S_EX1;
        end
      end
      S_WAIT: begin
        if (wcnt == 2'd0) begin
          load_ir = 1'b1;
          state_n = S_EX1;
        end else begin
          wcnt_n = wcnt - 2'd1;
        end
      end
      S_EX1:   if (ir[7]) state_n = S_EX2;
               else       state_n = run ? S_FETCH : S_IDLE;
      S_EX2:   state_n = S_EX3;
      S_EX3:   state_n = run ? S_FETCH : S_IDLE;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
`ifdef CONTROLLER_HALT_EN
    if (load_ir && instruction == 8'h00) state_n = S_HALT;
`endif
  end

  // The IR value seen by the output decode: on the capture edge the incoming
  // instruction is used so EX1 outputs are correct in the first execute cycle.
  assign ir_d = load_ir ? instruction : ir;

  // Output decode from the next state.
  always_comb begin
    rout_d      = 16'h0000;
    ren_d       = 16'h0000;
    addxor_d    = 1'b0;
    increment_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
`ifdef CONTROLLER_HALT_EN
    halted_d    = 1'b0;
`endif
    case (state_n)
      S_FETCH: begin
        increment_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_WAIT:  busy_d = 1'b1;
      S_EX1: begin
        busy_d = 1'b1;
        if (ir_d[7]) begin
          rout_d = 16'h0001 << ir_d[5:3];
          ren_d  = 16'h0200;
        end else begin
          rout_d = ir_d[6] ? 16'h0400 : (16'h0001 << ir_d[2:0]);
          ren_d  = 16'h0001 << ir_d[5:3];
          done_d = 1'b1;
        end
      end
      S_EX2: begin
        busy_d   = 1'b1;
        rout_d   = 16'h0001 << ir_d[2:0];
        ren_d    = 16'h0100;
        addxor_d = ir_d[6];
      end
      S_EX3: begin
        busy_d = 1'b1;
        rout_d = 16'h0100;
        ren_d  = 16'h0001 << ir_d[5:3];
        done_d = 1'b1;
      end
`ifdef CONTROLLER_HALT_EN
      S_HALT:  halted_d = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller.sv
module tb_controller;

  localparam int FW_B = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        run_a, run_b;
  logic [7:0]  instr_a, instr_b;
  logic [15:0] rout_a, ren_a, rout_b, ren_b;
  logic        addxor_a, increment_a, busy_a, done_a, halted_a;
  logic        addxor_b, increment_b, busy_b, done_b, halted_b;

  int n_checks = 0;
  int n_fails  = 0;

  typedef logic [36:0] vec_t;
  vec_t exp_q[$];

  always #5 clock = ~clock;

  controller #(.FETCH_WAIT(0)) dut_a (
    .clock(clock), .reset(reset), .run(run_a), .instruction(instr_a),
    .rout(rout_a), .ren(ren_a), .addxor(addxor_a), .increment(increment_a),
    .busy(busy_a), .done(done_a), .halted(halted_a)
  );

  controller #(.FETCH_WAIT(FW_B)) dut_b (
    .clock(clock), .reset(reset), .run(run_b), .instruction(instr_b),
    .rout(rout_b), .ren(ren_b), .addxor(addxor_b), .increment(increment_b),
    .busy(busy_b), .done(done_b), .halted(halted_b)
  );

  function automatic vec_t mk(logic [15:0] ro, logic [15:0] re, logic ax,
                              logic inc, logic bsy, logic dn, logic hl);
    return {ro, re, ax, inc, bsy, dn, hl};
  endfunction

  function automatic vec_t obs(int sel);
    if (sel == 0) return {rout_a, ren_a, addxor_a, increment_a, busy_a, done_a, halted_a};
    else          return {rout_b, ren_b, addxor_b, increment_b, busy_b, done_b, halted_b};
  endfunction

  function automatic logic [15:0] oh(logic [2:0] idx);
    logic [15:0] v;
    v = 16'h0000;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input int sel, input vec_t expv);
    vec_t o;
    o = obs(sel);
    n_checks++;
    assert (o === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, expv);
    end
  endtask

  task automatic set_run(input int sel, input logic v);
    if (sel == 0) run_a = v; else run_b = v;
  endtask

  task automatic set_instr(input int sel, input logic [7:0] v);
    if (sel == 0) instr_a = v; else instr_b = v;
  endtask

  // Reference trace for one instruction, cycle by cycle from FETCH entry.
  task automatic build(input logic [7:0] ins, input int fw);
    logic [2:0] rx, ry;
    rx = ins[5:3];
    ry = ins[2:0];
    exp_q = {};
    exp_q.push_back(mk(16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    repeat (fw) exp_q.push_back(mk(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
`ifdef CONTROLLER_HALT_EN
    if (ins == 8'h00) begin
      exp_q.push_back(mk(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      return;
    end
`endif
    case (ins[7:6])
      2'b00: exp_q.push_back(mk(oh(ry), oh(rx), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      2'b01: exp_q.push_back(mk(16'h0400, oh(rx), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      default: begin
        exp_q.push_back(mk(oh(rx), 16'h0200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(oh(ry), 16'h0100, ins[6], 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(16'h0100, oh(rx), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      end
    endcase
  endtask

  // Entered some time before a clock edge with the DUT in IDLE or in the final
  // execute cycle; the next edge enters FETCH.
  task automatic do_instr(input int sel, input logic [7:0] ins, input logic keep_run);
    int fw;
    int n;
    fw = (sel == 0) ? 0 : FW_B;
    build(ins, fw);
    n = exp_q.size();
    set_instr(sel, ins);
    set_run(sel, 1'b1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      check($sformatf("dut%0d ins=%h cyc%0d", sel, ins, i), sel, exp_q[i]);
      if (i == fw + 1) set_instr(sel, 8'($urandom));
      if (i == n - 1) set_run(sel, keep_run);
      else            set_run(sel, 1'($urandom));
    end
    if (!keep_run) begin
      @(posedge clock); #1;
      check($sformatf("dut%0d idle after %h", sel, ins), sel, '0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
        check($sformatf("dut%0d idle gap", sel), sel, '0);
      end
    end
  endtask

`ifdef CONTROLLER_HALT_EN
  task automatic do_halt(input int sel);
    int fw;
    fw = (sel == 0) ? 0 : FW_B;
    build(8'h00, fw);
    set_instr(sel, 8'h00);
    set_run(sel, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clock); #1;
      check($sformatf("dut%0d halt entry cyc%0d", sel, i), sel, exp_q[i]);
    end
    set_instr(sel, 8'h41);
    repeat (20) begin
      @(posedge clock); #1;
      check($sformatf("dut%0d halt hold", sel), sel, mk(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    set_run(sel, 1'b0);
    reset = 1'b1;
    #1;
    check($sformatf("dut%0d halt reset", sel), sel, '0);
    @(negedge clock);
    reset = 1'b0;
  endtask
`endif

  task automatic random_run(input int sel, input int count);
    logic [7:0] ins;
    logic       keep;
    for (int k = 0; k < count; k++) begin
      ins = 8'($urandom);
      if (ins == 8'h00) ins = 8'h09;
      keep = (k == count - 1) ? 1'b0 : 1'($urandom);
      do_instr(sel, ins, keep);
    end
  endtask

  initial begin
    reset   = 1'b1;
    run_a   = 1'b0;
    run_b   = 1'b0;
    instr_a = 8'h00;
    instr_b = 8'h00;
    #1;
    check("reset a", 0, '0);
    check("reset b", 1, '0);
    run_a = 1'b1;
    run_b = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset held a", 0, '0);
    check("reset held b", 1, '0);
    run_a = 1'b0;
    run_b = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
      check("idle a", 0, '0);
    end

    // Directed, no settle cycles
    do_instr(0, 8'h41, 1'b1);
    do_instr(0, 8'h81, 1'b1);
    do_instr(0, 8'hC1, 1'b0);
    do_instr(0, 8'h0A, 1'b1);
    do_instr(0, 8'hD2, 1'b0);

    // Directed, two settle cycles
    do_instr(1, 8'h41, 1'b0);
    do_instr(1, 8'h81, 1'b1);
    do_instr(1, 8'hC1, 1'b1);
    do_instr(1, 8'h7F, 1'b0);

    // Reset during EX2 of add
    build(8'h81, 0);
    set_instr(0, 8'h81);
    run_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check($sformatf("pre-reset cyc%0d", i), 0, exp_q[i]);
    end
    #2;
    reset = 1'b1;
    #1;
    check("async reset in EX2", 0, '0);
    @(negedge clock);
    reset = 1'b0;
    do_instr(0, 8'h41, 1'b0);

`ifdef CONTROLLER_HALT_EN
    do_halt(0);
    do_halt(1);
`else
    do_instr(0, 8'h00, 1'b0);
    do_instr(1, 8'h00, 1'b0);
`endif

    random_run(0, 30);
    random_run(1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
